// File: rtl/id_hazard_fwd_unit_pkg.sv
// Shared constants for the ID-stage forwarding/hazard unit: result latencies,
// downstream stage index names and the forward-readiness rule.
package id_hazard_fwd_unit_pkg;

    // Result latency classes (stages until the result appears on a stage bus)
    localparam int LAT_ALU  = 32'sd1;
    localparam int LAT_LOAD = 32'sd2;

    // Tracked downstream stage indices
    typedef enum logic [1:0] {
        STG_EX  = 2'd0,
        STG_MEM = 2'd1,
        STG_WB  = 2'd2
    } stage_e;

    // Entry field widths for the default configuration
    localparam int ENT_VALID_W = 32'sd1;
    localparam int ENT_DST_W   = 32'sd5;
    localparam int ENT_LAT_W   = 32'sd2;

    // A writer sitting at stage idx has its result on that stage's bus
    // once it has travelled at least lat stages.
    function automatic logic fwd_ready(input int idx, input int lat);
        return ((idx + 32'sd1) >= lat);
    endfunction

endpackage

// File: rtl/id_hazard_fwd_unit_if.sv
// Bundle of ID-stage operand/hazard signals between decoder side (master)
// and the forwarding unit (slave).
interface id_hazard_fwd_unit_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int STAGES     = 3,
    parameter int LAT_W      = 2
);
    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]            id_src_used;
    logic [REG_ADDR_W-1:0]         id_dst_addr;
    logic                          id_gpr_we_;
    logic [LAT_W-1:0]              id_lat;
    logic                          stall;
    logic                          flush;
    logic [NUM_SRC*DATA_W-1:0]     gpr_rd_data;
    logic [STAGES*DATA_W-1:0]      stage_fwd_data;
    logic [NUM_SRC*DATA_W-1:0]     src_data;
    logic                          ld_hazard;
    logic                          issue;

    modport master (
        output id_valid, id_src_addr, id_src_used, id_dst_addr, id_gpr_we_,
               id_lat, stall, flush, gpr_rd_data, stage_fwd_data,
        input  src_data, ld_hazard, issue
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_dst_addr, id_gpr_we_,
               id_lat, stall, flush, gpr_rd_data, stage_fwd_data,
        output src_data, ld_hazard, issue
    );
endinterface

// File: rtl/id_hazard_fwd_unit_fwd_select.sv
// Per-source operand resolution: finds the youngest in-flight writer of the
// source register and either forwards its stage result or flags not-ready.
module id_fwd_select
    import id_hazard_fwd_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STAGES     = 3,
    parameter int LAT_W      = 2,
    parameter int R0_ZERO    = 0
) (
    input  logic [REG_ADDR_W-1:0]        i_src_addr,
    input  logic                         i_src_used,
    input  logic [STAGES-1:0]            i_ent_valid,
    input  logic [STAGES*REG_ADDR_W-1:0] i_ent_dst,
    input  logic [STAGES*LAT_W-1:0]      i_ent_lat,
    input  logic [DATA_W-1:0]            i_gpr_data,
    input  logic [STAGES*DATA_W-1:0]     i_fwd_data,
    output logic [DATA_W-1:0]            o_data,
    output logic                         o_not_ready
);
    logic              w_is_r0;
    logic [STAGES-1:0] w_match;
    logic              w_hit;
    int                w_idx;

    assign w_is_r0 = (R0_ZERO != 0) && (i_src_addr == {REG_ADDR_W{1'b0}});

    for (genvar g = 0; g < STAGES; g++) begin : g_match
        assign w_match[g] = i_src_used & i_ent_valid[g] & ~w_is_r0 &
                            (i_ent_dst[g*REG_ADDR_W +: REG_ADDR_W] == i_src_addr);
    end

    // Priority pick of the youngest matching writer, then forward or flag not-ready
    always_comb begin
        w_hit       = 1'b0;
        w_idx       = 32'sd0;
        o_data      = i_gpr_data;
        o_not_ready = 1'b0;
        // Walk oldest to youngest so the youngest match is the one left standing
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_hit = w_match[i] ? 1'b1 : w_hit;
            w_idx = w_match[i] ? i    : w_idx;
        end
        if (w_hit) begin
            if (fwd_ready(w_idx, int'(i_ent_lat[w_idx*LAT_W +: LAT_W]))) begin
                o_data      = i_fwd_data[w_idx*DATA_W +: DATA_W];
                o_not_ready = 1'b0;
            end else begin
                o_data      = i_gpr_data;
                o_not_ready = 1'b1;
            end
        end else if (w_is_r0) begin
            o_data      = {DATA_W{1'b0}};
            o_not_ready = 1'b0;
        end else begin
            o_data      = i_gpr_data;
            o_not_ready = 1'b0;
        end
    end
endmodule

// File: rtl/id_hazard_fwd_unit.sv
// ID-stage forwarding and load-use hazard unit. Tracks in-flight register
// writers over STAGES downstream stages (needs STAGES >= 2) and resolves
// each source operand from the youngest ready writer or the register file.
module id_hazard_fwd_unit
    import id_hazard_fwd_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int STAGES     = 3,
    parameter int LAT_W      = 2,
    parameter int R0_ZERO    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    id_hazard_fwd_unit_if.slave   bus
);
    logic [STAGES-1:0]            r_valid;
    logic [STAGES*REG_ADDR_W-1:0] r_dst;
    logic [STAGES*LAT_W-1:0]      r_lat;

    logic [NUM_SRC-1:0]           w_not_ready;
    logic                         w_ld_hazard;
    logic                         w_issue;
    logic                         w_new_valid;
    logic [LAT_W-1:0]             w_new_lat;

    // A zero latency would mean "ready before EX"; it is clamped to the ALU case
    assign w_new_lat   = (bus.id_lat == {LAT_W{1'b0}}) ? LAT_W'(LAT_ALU) : bus.id_lat;
    assign w_ld_hazard = bus.id_valid & (|w_not_ready);
    assign w_issue     = bus.id_valid & ~w_ld_hazard & ~bus.stall & ~bus.flush;
    assign w_new_valid = w_issue & ~bus.id_gpr_we_;

    assign bus.ld_hazard = w_ld_hazard;
    assign bus.issue     = w_issue;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        id_fwd_select #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W),
            .STAGES     (STAGES),
            .LAT_W      (LAT_W),
            .R0_ZERO    (R0_ZERO)
        ) u_sel (
            .i_src_addr  (bus.id_src_addr[s*REG_ADDR_W +: REG_ADDR_W]),
            .i_src_used  (bus.id_src_used[s]),
            .i_ent_valid (r_valid),
            .i_ent_dst   (r_dst),
            .i_ent_lat   (r_lat),
            .i_gpr_data  (bus.gpr_rd_data[s*DATA_W +: DATA_W]),
            .i_fwd_data  (bus.stage_fwd_data),
            .o_data      (bus.src_data[s*DATA_W +: DATA_W]),
            .o_not_ready (w_not_ready[s])
        );
    end

    // Writer table: clear on reset/flush, freeze on stall, otherwise shift one
    // stage and insert the issuing writer (or a bubble) at EX
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_valid <= {STAGES{1'b0}};
            r_dst   <= {(STAGES*REG_ADDR_W){1'b0}};
            r_lat   <= {(STAGES*LAT_W){1'b0}};
        end else if (bus.stall) begin
            r_valid <= r_valid;
            r_dst   <= r_dst;
            r_lat   <= r_lat;
        end else begin
            r_valid <= {r_valid[STAGES-2:0], w_new_valid};
            r_dst   <= {r_dst[(STAGES-1)*REG_ADDR_W-1:0], bus.id_dst_addr};
            r_lat   <= {r_lat[(STAGES-1)*LAT_W-1:0], w_new_lat};
        end
    end
endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Scoreboard bench for id_hazard_fwd_unit: directed cycles push expected
// responses; a negedge monitor pops and compares. A second instance with
// R0_ZERO=1 sees identical inputs.
module tb_id_hazard_fwd_unit;
    import id_hazard_fwd_unit_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int ST = 3;
    localparam int LW = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Cycle counter used to tag expectations
    always @(posedge clk) cyc <= cyc + 1;

    id_hazard_fwd_unit_if #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .STAGES(ST), .LAT_W(LW)) bif ();
    id_hazard_fwd_unit_if #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .STAGES(ST), .LAT_W(LW)) bif_r0 ();

    assign bif_r0.id_valid       = bif.id_valid;
    assign bif_r0.id_src_addr    = bif.id_src_addr;
    assign bif_r0.id_src_used    = bif.id_src_used;
    assign bif_r0.id_dst_addr    = bif.id_dst_addr;
    assign bif_r0.id_gpr_we_     = bif.id_gpr_we_;
    assign bif_r0.id_lat         = bif.id_lat;
    assign bif_r0.stall          = bif.stall;
    assign bif_r0.flush          = bif.flush;
    assign bif_r0.gpr_rd_data    = bif.gpr_rd_data;
    assign bif_r0.stage_fwd_data = bif.stage_fwd_data;

    id_hazard_fwd_unit #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .STAGES(ST), .LAT_W(LW), .R0_ZERO(0))
        dut (.clk(clk), .reset(reset), .bus(bif));
    id_hazard_fwd_unit #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .STAGES(ST), .LAT_W(LW), .R0_ZERO(1))
        dut_r0 (.clk(clk), .reset(reset), .bus(bif_r0));

    typedef struct {
        int            cyc;
        bit            ci;
        bit            c0;
        bit            c1;
        logic          haz;
        logic          iss;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          r0_haz;
        logic          r0_iss;
        logic [DW-1:0] r0_d0;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation tagged for the current cycle
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL stale_expect cyc=%0d got=%0d expected=%0d", cyc, cyc, e.cyc);
            end else begin
                chk("ld_hazard", {31'd0, bif.ld_hazard}, {31'd0, e.haz});
                chk("r0_ld_hazard", {31'd0, bif_r0.ld_hazard}, {31'd0, e.r0_haz});
                if (e.ci) begin
                    chk("issue", {31'd0, bif.issue}, {31'd0, e.iss});
                    chk("r0_issue", {31'd0, bif_r0.issue}, {31'd0, e.r0_iss});
                end
                if (e.c0) begin
                    chk("src_data0", bif.src_data[DW-1:0], e.d0);
                    chk("r0_src_data0", bif_r0.src_data[DW-1:0], e.r0_d0);
                end
                if (e.c1) begin
                    chk("src_data1", bif.src_data[2*DW-1:DW], e.d1);
                    chk("r0_src_data1", bif_r0.src_data[2*DW-1:DW], e.d1);
                end
            end
        end
    end

    task automatic exp2(input logic haz, input bit ci, input logic iss,
                        input bit c0, input logic [DW-1:0] d0,
                        input bit c1, input logic [DW-1:0] d1,
                        input logic r0haz, input logic r0iss, input logic [DW-1:0] r0d0);
        exp_t e;
        e.cyc = cyc; e.ci = ci; e.c0 = c0; e.c1 = c1;
        e.haz = haz; e.iss = iss; e.d0 = d0; e.d1 = d1;
        e.r0_haz = r0haz; e.r0_iss = r0iss; e.r0_d0 = r0d0;
        q.push_back(e);
    endtask

    task automatic exp1(input logic haz, input bit ci, input logic iss,
                        input bit c0, input logic [DW-1:0] d0,
                        input bit c1, input logic [DW-1:0] d1);
        exp2(haz, ci, iss, c0, d0, c1, d1, haz, iss, d0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input logic [DW-1:0] ex, input logic [DW-1:0] mem, input logic [DW-1:0] wb);
        bif.stage_fwd_data = {wb, mem, ex};
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [1:0] used, input logic [AW-1:0] dst,
                          input logic we_n, input logic [LW-1:0] lat);
        bif.id_valid    = v;
        bif.id_src_addr = {a1, a0};
        bif.id_src_used = used;
        bif.id_dst_addr = dst;
        bif.id_gpr_we_  = we_n;
        bif.id_lat      = lat;
    endtask

    task automatic defaults();
        reset     = 1'b0;
        bif.stall = 1'b0;
        bif.flush = 1'b0;
        bif.gpr_rd_data = {32'h0000_0022, 32'h0000_0011};
        set_fwd(32'h0000_00E0, 32'h0000_00E1, 32'h0000_00E2);
        set_id(1'b0, 5'd5, 5'd6, 2'b00, 5'd0, 1'b1, 2'd1);
    endtask

    initial begin
        defaults();
        reset = 1'b1;
        next_cyc();
        // Test 1: issues, then 2 reset cycles (hazard visible in first, gone after)
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd3, 1'b0, 2'(LAT_ALU));
        exp1(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd1, 1'b0, 2'(LAT_LOAD));
        exp1(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        defaults(); reset = 1'b1; set_id(1'b1, 5'd5, 5'd1, 2'b10, 5'd0, 1'b1, 2'd1);
        exp1(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        defaults(); reset = 1'b1; set_id(1'b1, 5'd5, 5'd1, 2'b10, 5'd0, 1'b1, 2'd1);
        exp1(1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 32'h22);
        next_cyc();
        defaults(); set_id(1'b1, 5'd1, 5'd3, 2'b11, 5'd0, 1'b1, 2'd1);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b1, 32'h22);
        next_cyc();
        // Test 2: ALU result forwarded from EX, then MEM, then WB, then gpr
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd3, 1'b0, 2'(LAT_ALU));
        exp1(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd3, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        set_fwd(32'h99, 32'hE1, 32'hE2);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'h99, 1'b0, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd3, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        set_fwd(32'hE0, 32'h55, 32'hE2);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'h55, 1'b0, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd3, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        set_fwd(32'hE0, 32'hE1, 32'h77);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd3, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0);
        next_cyc();
        // Test 3: load-use one-cycle hazard, then forward from MEM
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd1, 1'b0, 2'(LAT_LOAD));
        exp1(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd5, 5'd1, 2'b10, 5'd0, 1'b1, 2'd1);
        exp1(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd5, 5'd1, 2'b10, 5'd0, 1'b1, 2'd1);
        set_fwd(32'hE0, 32'h96, 32'hE2);
        exp1(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h96);
        next_cyc();
        // Test 4: youngest writer wins; write-disabled instruction is not tracked
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd2, 1'b0, 2'd1);
        next_cyc();
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd2, 1'b0, 2'd1);
        next_cyc();
        defaults(); set_id(1'b1, 5'd2, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        set_fwd(32'hA0, 32'hB0, 32'hE2);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 32'h0);
        next_cyc();
        defaults(); next_cyc();
        defaults(); next_cyc();
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd2, 1'b1, 2'd1);
        next_cyc();
        defaults(); set_id(1'b1, 5'd2, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        set_fwd(32'hA0, 32'hB0, 32'hC0);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0);
        next_cyc();
        // Test 5: load frozen in EX by stall, then flushed
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd1, 1'b0, 2'(LAT_LOAD));
        next_cyc();
        for (int k = 0; k < 3; k++) begin
            defaults(); bif.stall = 1'b1; set_id(1'b1, 5'd1, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
            exp1(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            next_cyc();
        end
        defaults(); bif.stall = 1'b1; bif.flush = 1'b1; set_id(1'b1, 5'd1, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        exp1(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd1, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0);
        next_cyc();
        // Test 6: unused source ignores a pending load; r0 handling per instance
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd1, 1'b0, 2'(LAT_LOAD));
        next_cyc();
        defaults(); set_id(1'b1, 5'd5, 5'd1, 2'b01, 5'd0, 1'b1, 2'd1);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd0, 1'b0, 2'(LAT_ALU));
        next_cyc();
        defaults(); set_id(1'b1, 5'd0, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        set_fwd(32'hC0, 32'hE1, 32'hE2);
        exp2(1'b0, 1'b1, 1'b1, 1'b1, 32'hC0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd0, 1'b0, 2'(LAT_LOAD));
        next_cyc();
        defaults(); set_id(1'b1, 5'd0, 5'd6, 2'b01, 5'd0, 1'b1, 2'd1);
        exp2(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        next_cyc();
        // Zero latency behaves as ALU latency
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd6, 1'b0, 2'd0);
        next_cyc();
        defaults(); set_id(1'b1, 5'd6, 5'd5, 2'b01, 5'd0, 1'b1, 2'd1);
        set_fwd(32'hD0, 32'hE1, 32'hE2);
        exp1(1'b0, 1'b1, 1'b1, 1'b1, 32'hD0, 1'b0, 32'h0);
        next_cyc();
        // Latency-3 writer: two hazard cycles, then forwarded from WB
        defaults(); set_id(1'b1, 5'd5, 5'd6, 2'b00, 5'd7, 1'b0, 2'd3);
        next_cyc();
        for (int k = 0; k < 2; k++) begin
            defaults(); set_id(1'b1, 5'd5, 5'd7, 2'b10, 5'd0, 1'b1, 2'd1);
            exp1(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            next_cyc();
        end
        defaults(); set_id(1'b1, 5'd5, 5'd7, 2'b10, 5'd0, 1'b1, 2'd1);
        set_fwd(32'hE0, 32'hE1, 32'h3C);
        exp1(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3C);
        next_cyc();
        defaults();
        next_cyc();
        next_cyc();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end
endmodule
